// File: rtl/imem_loader_responder.sv
// Instruction memory for the core fetch port, preloaded from a little-endian byte stream.
// Holds the core in reset until the whole image has been packed and written.
//
// state    | meaning
// ST_IDLE  | waiting for the first image byte
// ST_LOAD  | packing bytes into words and writing them
// ST_RUN   | image complete, core released, fetches served from memory
// ST_ERROR | image overflowed the memory, core held in reset

`ifndef RESET_ADDRESS
`define RESET_ADDRESS 32'h0000_0000
`endif

module imem_loader_responder #(
   parameter int unsigned DepthWords  = 1024,
   parameter logic [31:0] BaseAddress = `RESET_ADDRESS
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] icache_read_address_i,
   output logic [31:0] icache_read_data_o,
   input  logic        load_valid_i,
   output logic        load_ready_o,
   input  logic [7:0]  load_byte_i,
   input  logic        load_last_i,
   output logic        core_rst_o,
   output logic        load_done_o,
   output logic        load_error_o
);

   localparam int unsigned AW        = $clog2(DepthWords);
   localparam int unsigned CW        = AW + 1;
   localparam logic [31:0] Nop       = 32'h0000_0013;
   localparam logic [31:0] SizeBytes = 32'(4 * DepthWords);
   localparam logic [CW-1:0] DepthCnt = CW'(DepthWords);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_ERROR
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    byte_cnt_q, byte_cnt_d;
   logic [CW-1:0] word_cnt_q, word_cnt_d;
   logic [23:0]   shift_q, shift_d;

   logic [31:0]   mem_q [DepthWords];
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [31:0]   word_fill;
   logic          accept;

   logic [31:0]   rd_off;
   logic          rd_hit;

   assign load_ready_o = (state_q == ST_IDLE) || (state_q == ST_LOAD);
   assign core_rst_o   = (state_q != ST_RUN);
   assign load_done_o  = (state_q == ST_RUN);
   assign load_error_o = (state_q == ST_ERROR);

   assign accept = load_valid_i && load_ready_o;

   // Pending bytes sit in their final lane, so the incoming byte just drops into its slot;
   // lanes above byte_cnt are always zero because shift is cleared after every word.
   always_comb begin
      word_fill = {8'h00, shift_q};
      case (byte_cnt_q)
         2'd0:    word_fill[7:0]   = load_byte_i;
         2'd1:    word_fill[15:8]  = load_byte_i;
         2'd2:    word_fill[23:16] = load_byte_i;
         default: word_fill[31:24] = load_byte_i;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      word_cnt_d = word_cnt_q;
      shift_d    = shift_q;
      mem_we     = 1'b0;
      mem_waddr  = word_cnt_q[AW-1:0];

      if (accept) begin
         if (word_cnt_q == DepthCnt) begin
            state_d = ST_ERROR;
         end else begin
            state_d = ST_LOAD;
            if (load_last_i || (byte_cnt_q == 2'd3)) begin
               mem_we     = 1'b1;
               word_cnt_d = word_cnt_q + 1'b1;
               byte_cnt_d = 2'd0;
               shift_d    = 24'h0;
               if (load_last_i) begin
                  state_d = ST_RUN;
               end
            end else begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               shift_d    = word_fill[23:0];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         byte_cnt_q <= 2'd0;
         word_cnt_q <= '0;
         shift_q    <= 24'h0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_cnt_q <= word_cnt_d;
         shift_q    <= shift_d;
      end
   end

   // Storage is deliberately not reset; only the write is suppressed while in reset.
   always_ff @(posedge clk_i) begin
      if (rst_ni && mem_we) begin
         mem_q[mem_waddr] <= word_fill;
      end
   end

   // Addresses below BaseAddress wrap to a huge offset and fail the range test.
   assign rd_off = icache_read_address_i - BaseAddress;

   always_comb begin
      rd_hit = (state_q == ST_RUN) && (rd_off[1:0] == 2'b00) && (rd_off < SizeBytes);
      icache_read_data_o = rd_hit ? mem_q[rd_off[AW+1:2]] : Nop;
   end

endmodule

// File: tb/tb_imem_loader_responder.sv
// Bench for imem_loader_responder: streams images, queues the expected fetch words,
// then drains the queue by reading the fetch port once the core is released.

module tb_imem_loader_responder;

   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [31:0] icache_read_address_i = 32'h0;
   logic [31:0] icache_read_data_o;
   logic        load_valid_i = 1'b0;
   logic        load_ready_o;
   logic [7:0]  load_byte_i = 8'h00;
   logic        load_last_i = 1'b0;
   logic        core_rst_o;
   logic        load_done_o;
   logic        load_error_o;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } sb_t;

   sb_t         sb[$];
   logic [7:0]  img[$];
   int          n_cmp = 0;
   int          n_err = 0;

   imem_loader_responder #(
      .DepthWords (DEPTH),
      .BaseAddress(BASE)
   ) dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .icache_read_address_i(icache_read_address_i),
      .icache_read_data_o   (icache_read_data_o),
      .load_valid_i         (load_valid_i),
      .load_ready_o         (load_ready_o),
      .load_byte_i          (load_byte_i),
      .load_last_i          (load_last_i),
      .core_rst_o           (core_rst_o),
      .load_done_o          (load_done_o),
      .load_error_o         (load_error_o)
   );

   always #5 clk_i = ~clk_i;

   // rst_ni low across exactly one rising edge
   task automatic do_reset();
      @(negedge clk_i);
      rst_ni       = 1'b0;
      load_valid_i = 1'b0;
      load_last_i  = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic push_byte(input logic [7:0] b, input logic last);
      @(negedge clk_i);
      load_valid_i = 1'b1;
      load_byte_i  = b;
      load_last_i  = last;
      @(posedge clk_i);
   endtask

   task automatic idle_cycle();
      @(negedge clk_i);
      load_valid_i = 1'b0;
      load_last_i  = 1'b0;
   endtask

   task automatic load_image(input bit use_last, input bit gaps);
      for (int i = 0; i < img.size(); i++) begin
         push_byte(img[i], use_last && (i == img.size() - 1));
         if (gaps) idle_cycle();
      end
      idle_cycle();
   endtask

   task automatic read_word(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk_i);
      icache_read_address_i = addr;
      #1;
      data = icache_read_data_o;
   endtask

   // Reference packing: byte k of the image is bits [8*(k%4)+:8] of word k/4.
   task automatic expect_image();
      logic [31:0] w;
      for (int i = 0; i < (img.size() + 3) / 4; i++) begin
         w = 32'h0;
         for (int j = 0; j < 4; j++) begin
            if (4 * i + j < img.size()) w[8*j +: 8] = img[4*i+j];
         end
         sb.push_back('{addr: BASE + 32'(4 * i), data: w});
      end
   endtask

   task automatic random_image(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic test_reset();
      logic [31:0] got;
      do_reset();
      n_cmp++;
      if ({load_ready_o, core_rst_o, load_done_o, load_error_o} !== 4'b1100) begin
         n_err++;
         $display("FAIL reset_outputs: got rdy/crst/done/err=%b want 1100",
                  {load_ready_o, core_rst_o, load_done_o, load_error_o});
      end
      read_word(BASE, got);
      n_cmp++;
      if (got !== NOP) begin
         n_err++;
         $display("FAIL reset_read: got %h want %h", got, NOP);
      end
   endtask

   task automatic test_image_load();
      logic [31:0] got;
      sb_t e;
      do_reset();
      img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      sb.push_back('{addr: BASE,      data: 32'h0000_0013});
      sb.push_back('{addr: BASE + 4,  data: 32'h0010_0093});
      for (int i = 0; i < 5; i++) push_byte(img[i], 1'b0);
      idle_cycle();
      // word 0 is already written here, yet fetches must still see NOP
      icache_read_address_i = BASE + 4;
      read_word(BASE + 4, got);
      read_word(BASE, got);
      n_cmp++;
      if (got !== NOP || core_rst_o !== 1'b1 || load_done_o !== 1'b0) begin
         n_err++;
         $display("FAIL load_midway: got data=%h crst=%b done=%b want %h 1 0",
                  got, core_rst_o, load_done_o, NOP);
      end
      for (int i = 5; i < 8; i++) push_byte(img[i], i == 7);
      idle_cycle();
      n_cmp++;
      if (core_rst_o !== 1'b0 || load_done_o !== 1'b1 || load_ready_o !== 1'b0) begin
         n_err++;
         $display("FAIL t1_run_entry: got crst=%b done=%b rdy=%b want 0 1 0",
                  core_rst_o, load_done_o, load_ready_o);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         read_word(e.addr, got);
         n_cmp++;
         if (got !== e.data) begin
            n_err++;
            $display("FAIL t1_read @%h: got %h want %h", e.addr, got, e.data);
         end
      end
   endtask

   task automatic test_partial_word();
      logic [31:0] got;
      sb_t e;
      do_reset();
      img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
      sb.push_back('{addr: BASE,     data: 32'h0403_0201});
      sb.push_back('{addr: BASE + 4, data: 32'h0000_00AA});
      load_image(1'b1, 1'b0);
      n_cmp++;
      if (load_done_o !== 1'b1) begin
         n_err++;
         $display("FAIL t2_done: got %b want 1", load_done_o);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         read_word(e.addr, got);
         n_cmp++;
         if (got !== e.data) begin
            n_err++;
            $display("FAIL t2_read @%h: got %h want %h", e.addr, got, e.data);
         end
      end
   endtask

   task automatic test_bounds();
      logic [31:0] got;
      logic [31:0] addrs[5];
      addrs = '{BASE + 2, BASE + 1, BASE + 32'(4 * DEPTH), BASE - 4, 32'hFFFF_FFFC};
      for (int i = 0; i < 5; i++) begin
         read_word(addrs[i], got);
         n_cmp++;
         if (got !== NOP) begin
            n_err++;
            $display("FAIL bounds_nop @%h: got %h want %h", addrs[i], got, NOP);
         end
      end
      read_word(BASE + 4, got);
      n_cmp++;
      if (got !== 32'h0000_00AA) begin
         n_err++;
         $display("FAIL bounds_inrange: got %h want 000000aa", got);
      end
   endtask

   task automatic test_full_image();
      logic [31:0] got;
      sb_t e;
      do_reset();
      random_image(4 * DEPTH);
      expect_image();
      load_image(1'b1, 1'b0);
      n_cmp++;
      if (load_done_o !== 1'b1 || load_error_o !== 1'b0 || core_rst_o !== 1'b0) begin
         n_err++;
         $display("FAIL full_image_state: got done=%b err=%b crst=%b want 1 0 0",
                  load_done_o, load_error_o, core_rst_o);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         read_word(e.addr, got);
         n_cmp++;
         if (got !== e.data) begin
            n_err++;
            $display("FAIL full_read @%h: got %h want %h", e.addr, got, e.data);
         end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] got;
      do_reset();
      random_image(4 * DEPTH);
      load_image(1'b0, 1'b0);
      n_cmp++;
      if (load_error_o !== 1'b0 || load_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL overflow_before: got err=%b rdy=%b want 0 1", load_error_o, load_ready_o);
      end
      push_byte(8'h5A, 1'b0);
      idle_cycle();
      n_cmp++;
      if ({load_error_o, load_ready_o, core_rst_o, load_done_o} !== 4'b1010) begin
         n_err++;
         $display("FAIL overflow_state: got err/rdy/crst/done=%b want 1010",
                  {load_error_o, load_ready_o, core_rst_o, load_done_o});
      end
      read_word(BASE, got);
      n_cmp++;
      if (got !== NOP) begin
         n_err++;
         $display("FAIL overflow_read: got %h want %h", got, NOP);
      end
   endtask

   task automatic test_reset_mid_load();
      logic [31:0] got;
      sb_t e;
      do_reset();
      push_byte(8'hAA, 1'b0);
      push_byte(8'hBB, 1'b0);
      push_byte(8'hCC, 1'b0);
      do_reset();
      n_cmp++;
      if (load_ready_o !== 1'b1 || core_rst_o !== 1'b1 || load_done_o !== 1'b0) begin
         n_err++;
         $display("FAIL midload_reset: got rdy=%b crst=%b done=%b want 1 1 0",
                  load_ready_o, core_rst_o, load_done_o);
      end
      random_image(8);
      expect_image();
      load_image(1'b1, 1'b0);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         read_word(e.addr, got);
         n_cmp++;
         if (got !== e.data) begin
            n_err++;
            $display("FAIL midload_read @%h: got %h want %h", e.addr, got, e.data);
         end
      end
   endtask

   task automatic test_gaps_and_run_ignore();
      logic [31:0] got;
      sb_t e;
      do_reset();
      img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      sb.push_back('{addr: BASE,     data: 32'h0000_0013});
      sb.push_back('{addr: BASE + 4, data: 32'h0010_0093});
      load_image(1'b1, 1'b1);
      n_cmp++;
      if (load_done_o !== 1'b1 || core_rst_o !== 1'b0) begin
         n_err++;
         $display("FAIL gaps_done: got done=%b crst=%b want 1 0", load_done_o, core_rst_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         load_valid_i = 1'b1;
         load_byte_i  = 8'hFF;
         load_last_i  = (i == 2);
         #1;
         n_cmp++;
         if (load_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL run_ready: got %b want 0", load_ready_o);
         end
      end
      idle_cycle();
      n_cmp++;
      if (load_done_o !== 1'b1 || load_error_o !== 1'b0) begin
         n_err++;
         $display("FAIL run_stays: got done=%b err=%b want 1 0", load_done_o, load_error_o);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         read_word(e.addr, got);
         n_cmp++;
         if (got !== e.data) begin
            n_err++;
            $display("FAIL gaps_read @%h: got %h want %h", e.addr, got, e.data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_image_load();
      test_partial_word();
      test_bounds();
      test_full_image();
      test_overflow();
      test_reset_mid_load();
      test_gaps_and_run_ignore();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
